mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 No parameters; data width fixed at 32, lanes fixed at 2 (lane 1 = older instruction, lane 0 = younger/slot).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 resetn  in  1  synchronous reset, active-high (asserted = 1 despite the name), sampled on posedge clk.
REQ-004 in_valid  in  2  per-lane instruction valid from execute.
REQ-005 in_memtoreg / in_memwrite / in_regwrite / in_signext  in  2 each  per-lane load, store, register-write, sign-extend-load flags.
REQ-006 in_msize  in  2x2  per-lane access size: 0 = byte, 1 = half, 2 = word.
REQ-007 in_addr / in_wdata / in_alu_out  in  2x32 each  per-lane effective address, store data, ALU result.
REQ-008 in_rdst  in  2x5  per-lane destination register.
REQ-009 flush  in  1  kill the pair currently held in the stage.
REQ-010 d_wait  out  1  stall to execute; input is accepted only when d_wait = 0.
REQ-011 dreq_valid / dreq_addr / dreq_size / dreq_strobe / dreq_data  out  1/32/2/4/32  data-cache request.
REQ-012 dresp_addr_ok / dresp_data_ok / dresp_data  in  1/1/32  cache accept, data return, read data.
REQ-013 out_valid / out_regwrite  out  2 each; out_rdst  out  2x5; out_result  out  2x32  retired pair to writeback.

Function
REQ-014 FSM states: IDLE, REQ1, WAIT1, REQ0, WAIT0, DRAIN.
REQ-015 d_wait = (state != IDLE).
REQ-016 IDLE, flush = 0, any in_valid = 1: capture the pair into stage registers; next state is REQ1 if lane 1 is valid with memtoreg or memwrite set, else REQ0 if lane 0 qualifies, else retire at the same edge.
REQ-017 Non-memory pair: out_* registered at the capture edge, so latency is one cycle.
REQ-018 REQx: dreq_valid = 1 with lane x fields, held stable until dresp_addr_ok; the edge with addr_ok moves to WAITx.
REQ-019 WAITx: on dresp_data_ok, latch lane x load data, then go to REQ0 (lane 1 done and lane 0 is a memory op) or retire and go to IDLE.
REQ-020 addr_ok and data_ok in the same REQx cycle: the access completes at that edge, bypassing WAITx.
REQ-021 Retire: out_valid = captured in_valid for one cycle only; otherwise out_valid = 0.
REQ-022 Lane result: load data for loads, else in_alu_out.
REQ-023 dreq_size = in_msize.
REQ-024 dreq_strobe is 0 for loads; for stores: byte = 4'b0001 << addr[1:0], half = 4'b0011 << addr[1:0], word = 4'b1111.
REQ-025 dreq_data: byte replicated x4, half replicated x2, word unchanged.
REQ-026 Load extraction: shift dresp_data right by addr[1:0]*8, then sign-extend if in_signext else zero-extend, to 8/16/32 bits.
REQ-027 Addresses arrive aligned (execute already suppresses misaligned accesses); no alignment check is performed.
REQ-028 Flush in IDLE: input not captured.
REQ-029 Flush in REQx without addr_ok: go to IDLE, no retire.
REQ-030 Flush in WAITx, or in REQx together with addr_ok: go to DRAIN, wait for data_ok, go to IDLE, no retire, no further requests.
REQ-031 Lane 1 is always accessed before lane 0; at most one request is outstanding.

Reset
REQ-032 While resetn = 1: state = IDLE, d_wait = 0, dreq_valid = 0, out_valid = 0, out_regwrite = 0, out_result = 0, out_rdst = 0, stage registers cleared.
REQ-033 Reset mid-transaction abandons it; a data_ok arriving after reset is ignored in IDLE.

Verification
REQ-034 ALU pair, lane1 alu_out = 0x11, lane0 alu_out = 0x22 -> next cycle out_valid = 2'b11 with those results; d_wait stays 0.
REQ-035 Lane 1 lb, addr 0x1003, signext = 1, data 0x80xxxxxx, addr_ok at t+1, data_ok at t+3 -> d_wait high t+1..t+3; out_result[1] = 0xFFFFFF80; out_valid pulses once.
REQ-036 Dual memory pair: lane1 sh 0xBEEF to 0x2002, lane0 lw 0x3000 -> first request strobe 4'b1100, data 0xBEEFBEEF; second request follows only after first data_ok; lane 0 result = returned word.
REQ-037 Lane 0 lhu 0x4002, data 0x8001xxxx, addr_ok and data_ok in the same cycle -> result 0x00008001, two-cycle total latency.
REQ-038 Flush asserted in WAIT1 -> DRAIN until data_ok, then IDLE; out_valid stays 0; no lane-0 request issued.
REQ-039 resetn asserted during REQ1 -> next cycle dreq_valid = 0, d_wait = 0, out_valid = 0.

Source files
------------

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-cache request/response bus between the memory stage and the cache
interface mem_access_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - two-lane memory access stage, lane 1 accessed before lane 0
module mem_access (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        in_valid,
  input  logic [1:0]        in_memtoreg,
  input  logic [1:0]        in_memwrite,
  input  logic [1:0]        in_regwrite,
  input  logic [1:0]        in_signext,
  input  logic [1:0][1:0]   in_msize,
  input  logic [1:0][31:0]  in_addr,
  input  logic [1:0][31:0]  in_wdata,
  input  logic [1:0][31:0]  in_alu_out,
  input  logic [1:0][4:0]   in_rdst,
  input  logic              flush,
  output logic              d_wait,
  mem_access_if.master      dbus,
  output logic [1:0]        out_valid,
  output logic [1:0]        out_regwrite,
  output logic [1:0][4:0]   out_rdst,
  output logic [1:0][31:0]  out_result
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ0, WAIT0, DRAIN} state_t;

  state_t state, next_state, adv_state;

  logic [1:0]       s_valid, s_memtoreg, s_memwrite, s_regwrite, s_signext;
  logic [1:0][1:0]  s_msize;
  logic [1:0][31:0] s_addr, s_wdata, s_alu_out, s_ldata;
  logic [1:0][4:0]  s_rdst;

  logic [1:0]       s_mem;
  logic             cur_lane;
  logic             capture, ret_cap, ret_stage, ld_en, adv_retire;
  logic [31:0]      ld_shift, ld_val;
  logic [1:0][31:0] fin_result;

  assign s_mem    = s_valid & (s_memtoreg | s_memwrite);
  assign cur_lane = (state == REQ1) || (state == WAIT1);
  assign d_wait   = (state != IDLE);

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else        state <= next_state;
  end

  // Next state plus capture / load-latch / retire strobes
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    ret_cap    = 1'b0;
    ret_stage  = 1'b0;
    ld_en      = 1'b0;
    adv_retire = !(cur_lane && s_mem[0]);
    adv_state  = adv_retire ? IDLE : REQ0;
    case (state)
      IDLE: begin
        if (!flush && (in_valid != 2'b00)) begin
          capture = 1'b1;
          if (in_valid[1] && (in_memtoreg[1] || in_memwrite[1]))      next_state = REQ1;
          else if (in_valid[0] && (in_memtoreg[0] || in_memwrite[0])) next_state = REQ0;
          else                                                        ret_cap = 1'b1;
        end
      end
      REQ1, REQ0: begin
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) begin
            // access finished at the accept edge; a flush here just drops it
            ld_en = !flush;
            if (flush) next_state = IDLE;
            else begin
              next_state = adv_state;
              ret_stage  = adv_retire;
            end
          end else if (flush) next_state = DRAIN;
          else next_state = (state == REQ1) ? WAIT1 : WAIT0;
        end else if (flush) begin
          next_state = IDLE;
        end
      end
      WAIT1, WAIT0: begin
        if (dbus.dresp_data_ok) begin
          ld_en = !flush;
          if (flush) next_state = IDLE;
          else begin
            next_state = adv_state;
            ret_stage  = adv_retire;
          end
        end else if (flush) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (dbus.dresp_data_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields of the lane currently being accessed, with store lane/byte formatting
  always_comb begin
    dbus.dreq_valid  = (state == REQ1) || (state == REQ0);
    dbus.dreq_addr   = s_addr[cur_lane];
    dbus.dreq_size   = s_msize[cur_lane];
    dbus.dreq_data   = s_wdata[cur_lane];
    dbus.dreq_strobe = 4'b1111;
    case (s_msize[cur_lane])
      2'd0: begin
        dbus.dreq_data   = {4{s_wdata[cur_lane][7:0]}};
        dbus.dreq_strobe = 4'b0001 << s_addr[cur_lane][1:0];
      end
      2'd1: begin
        dbus.dreq_data   = {2{s_wdata[cur_lane][15:0]}};
        dbus.dreq_strobe = 4'b0011 << s_addr[cur_lane][1:0];
      end
      default: ;
    endcase
    if (!s_memwrite[cur_lane]) dbus.dreq_strobe = 4'b0000;
  end

  // Load extraction: align the addressed bytes to bit 0, then sign/zero extend
  always_comb begin
    ld_shift = dbus.dresp_data >> {s_addr[cur_lane][1:0], 3'b000};
    case (s_msize[cur_lane])
      2'd0:    ld_val = {{24{s_signext[cur_lane] & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_val = {{16{s_signext[cur_lane] & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  // Final per-lane result; the lane finishing this cycle takes its data straight off the bus
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (s_valid[i] && s_memtoreg[i])
        fin_result[i] = (ld_en && (cur_lane == i[0])) ? ld_val : s_ldata[i];
      else
        fin_result[i] = s_alu_out[i];
    end
  end

  // Stage registers, load-data latches and the one-cycle retire outputs
  always_ff @(posedge clk) begin
    if (resetn) begin
      s_valid      <= '0;
      s_memtoreg   <= '0;
      s_memwrite   <= '0;
      s_regwrite   <= '0;
      s_signext    <= '0;
      s_msize      <= '0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_alu_out    <= '0;
      s_ldata      <= '0;
      s_rdst       <= '0;
      out_valid    <= '0;
      out_regwrite <= '0;
      out_rdst     <= '0;
      out_result   <= '0;
    end else begin
      out_valid <= 2'b00;
      if (capture) begin
        s_valid    <= in_valid;
        s_memtoreg <= in_memtoreg;
        s_memwrite <= in_memwrite;
        s_regwrite <= in_regwrite;
        s_signext  <= in_signext;
        s_msize    <= in_msize;
        s_addr     <= in_addr;
        s_wdata    <= in_wdata;
        s_alu_out  <= in_alu_out;
        s_rdst     <= in_rdst;
        s_ldata    <= '0;
      end
      if (ld_en) s_ldata[cur_lane] <= ld_val;
      if (ret_cap) begin
        out_valid    <= in_valid;
        out_regwrite <= in_valid & in_regwrite;
        out_rdst     <= in_rdst;
        out_result   <= in_alu_out;
      end
      if (ret_stage) begin
        out_valid    <= s_valid;
        out_regwrite <= s_valid & s_regwrite;
        out_rdst     <= s_rdst;
        out_result   <= fin_result;
      end
    end
  end

endmodule
